// File: rtl/sprite_loader_if.sv
// Shared bus between the sprite loader and its CPU/video side: shadow writes, vblank, and the sprite load bus.
interface sprite_loader_if #(
  parameter int NUM_SPRITES = 8,
  parameter int IDX_W       = 3
);
  logic                   vblank;
  logic                   wr_en;
  logic [IDX_W-1:0]       wr_addr;
  logic                   wr_field;
  logic [16:0]            wr_data;
  logic [9:0]             x;
  logic [8:0]             y;
  logic                   visible;
  logic [NUM_SPRITES-1:0] load_pos;
  logic [NUM_SPRITES-1:0] load_att;
  logic                   busy;
  logic                   done;

  modport master (
    output vblank, wr_en, wr_addr, wr_field, wr_data,
    input  x, y, visible, load_pos, load_att, busy, done
  );

  modport slave (
    input  vblank, wr_en, wr_addr, wr_field, wr_data,
    output x, y, visible, load_pos, load_att, busy, done
  );
endinterface

// File: rtl/sprite_loader.sv
// Shadow table of sprite position/flip/visibility, committed to the sprite bank only on a vblank rising edge.
// Dirty sprites cost SCAN/POS/ATT (3 cycles), clean ones a single SCAN cycle; CPU writes are never stalled.
module sprite_loader #(
  parameter int NUM_SPRITES = 8,
  parameter int IDX_W       = 3
) (
  input  logic           clk,
  input  logic           rst,
  sprite_loader_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] POS  = 2'd2;
  localparam logic [1:0] ATT  = 2'd3;

  localparam logic [IDX_W:0]   NUM_W = (IDX_W+1)'(NUM_SPRITES);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_SPRITES - 1);

  typedef struct packed {
    logic [8:0] px;
    logic [7:0] py;
    logic       vis;
    logic       vf;
    logic       hf;
  } entry_t;

  entry_t                 shadow [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] dirty;
  logic [IDX_W-1:0]       idx;
  logic [1:0]             state;
  logic                   vblank_d;
  logic                   addr_ok;
  logic [NUM_SPRITES-1:0] idx_onehot;

  assign addr_ok    = ({1'b0, bus.wr_addr} < NUM_W);
  assign idx_onehot = NUM_SPRITES'(1) << idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      dirty        <= '0;
      vblank_d     <= 1'b1;
      bus.x        <= '0;
      bus.y        <= '0;
      bus.visible  <= 1'b0;
      bus.load_pos <= '0;
      bus.load_att <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      vblank_d <= bus.vblank;
      bus.done <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.vblank && !vblank_d && (|dirty)) begin
            state    <= SCAN;
            idx      <= '0;
            bus.busy <= 1'b1;
          end
        end
        SCAN: begin
          if (dirty[idx]) begin
            bus.x        <= {shadow[idx].px, shadow[idx].hf};
            bus.y        <= {shadow[idx].py, shadow[idx].vf};
            bus.visible  <= shadow[idx].vis;
            bus.load_pos <= idx_onehot;
            dirty[idx]   <= 1'b0;
            state        <= POS;
          end else if (idx == LAST) begin
            state    <= IDLE;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        POS: begin
          bus.load_pos <= '0;
          bus.load_att <= idx_onehot;
          state        <= ATT;
        end
        ATT: begin
          bus.load_att <= '0;
          if (idx == LAST) begin
            state    <= IDLE;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
          end else begin
            idx   <= idx + 1'b1;
            state <= SCAN;
          end
        end
        default: state <= IDLE;
      endcase

      // Placed after the SCAN clear so a same-cycle CPU write keeps the entry dirty for next frame.
      if (bus.wr_en && addr_ok) begin
        if (bus.wr_field) begin
          shadow[bus.wr_addr].vis <= bus.wr_data[2];
          shadow[bus.wr_addr].vf  <= bus.wr_data[1];
          shadow[bus.wr_addr].hf  <= bus.wr_data[0];
        end else begin
          shadow[bus.wr_addr].px <= bus.wr_data[16:8];
          shadow[bus.wr_addr].py <= bus.wr_data[7:0];
        end
        dirty[bus.wr_addr] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sprite_loader.sv
// Directed + randomized bench for sprite_loader; expected strobe schedule derived from per-sprite commit costs.
module tb_sprite_loader;
  localparam int N    = 8;
  localparam int MAXL = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sprite_loader_if #(.NUM_SPRITES(N), .IDX_W(3)) bus8 ();
  sprite_loader_if #(.NUM_SPRITES(6), .IDX_W(3)) bus6 ();

  sprite_loader #(.NUM_SPRITES(N), .IDX_W(3)) dut  (.clk(clk), .rst(rst), .bus(bus8));
  sprite_loader #(.NUM_SPRITES(6), .IDX_W(3)) dut6 (.clk(clk), .rst(rst), .bus(bus6));

  int n_assert = 0;
  int n_fail   = 0;

  // Reference shadow table
  logic [8:0]   mx   [N];
  logic [7:0]   my   [N];
  logic         mvis [N];
  logic         mvf  [N];
  logic         mhf  [N];
  logic [N-1:0] mdirty;

  // Expected per-cycle outputs of one frame, indexed by cycles after the trigger edge
  logic [N-1:0] ep [MAXL];
  logic [N-1:0] ea [MAXL];
  logic         eb [MAXL];
  logic         ed [MAXL];
  logic [9:0]   ex [MAXL];
  logic [8:0]   ey [MAXL];
  logic         ev [MAXL];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},     32'(bus8.busy),     32'd0);
    chk({tag, "_done"},     32'(bus8.done),     32'd0);
    chk({tag, "_load_pos"}, 32'(bus8.load_pos), 32'd0);
    chk({tag, "_load_att"}, 32'(bus8.load_att), 32'd0);
    chk({tag, "_x"},        32'(bus8.x),        32'd0);
    chk({tag, "_y"},        32'(bus8.y),        32'd0);
    chk({tag, "_visible"},  32'(bus8.visible),  32'd0);
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mx[k] = '0; my[k] = '0; mvis[k] = 1'b0; mvf[k] = 1'b0; mhf[k] = 1'b0;
    end
    mdirty = '0;
  endtask

  task automatic model_fields(input int a, input logic f, input logic [16:0] d);
    if (f) begin
      mvis[a] = d[2]; mvf[a] = d[1]; mhf[a] = d[0];
    end else begin
      mx[a] = d[16:8]; my[a] = d[7:0];
    end
  endtask

  task automatic wr(input int a, input logic f, input logic [16:0] d);
    @(negedge clk);
    bus8.wr_en = 1'b1; bus8.wr_addr = 3'(a); bus8.wr_field = f; bus8.wr_data = d;
    @(posedge clk);
    #1 bus8.wr_en = 1'b0;
    model_fields(a, f, d);
    mdirty[a] = 1'b1;
  endtask

  // One vblank frame with an optional write mid-pass, optional early vblank drop, optional reset.
  task automatic run_frame(input int mw_step, input int mw_addr, input logic mw_field,
                           input logic [16:0] mw_data, input int drop_step, input int rst_step);
    int c, L, s, w;
    logic d;
    logic [N-1:0] post;
    logic [8:0] px; logic [7:0] py; logic pv, pvf, phf;
    for (int j = 0; j < MAXL; j++) begin
      ep[j] = '0; ea[j] = '0; eb[j] = 1'b0; ed[j] = 1'b0; ex[j] = '0; ey[j] = '0; ev[j] = 1'b0;
    end
    w = mw_step + 1;
    post = mdirty;
    if (mdirty == '0) begin
      L = 4;
      if (mw_step >= 0) post[mw_addr] = 1'b1;
    end else begin
      c = 1;
      post = '0;
      for (int k = 0; k < N; k++) begin
        s = c;
        px = mx[k]; py = my[k]; pv = mvis[k]; pvf = mvf[k]; phf = mhf[k];
        d = mdirty[k];
        if (mw_step >= 0 && mw_addr == k) begin
          if (w < s) begin
            d = 1'b1;
            if (mw_field) begin pv = mw_data[2]; pvf = mw_data[1]; phf = mw_data[0]; end
            else begin px = mw_data[16:8]; py = mw_data[7:0]; end
          end else begin
            post[k] = 1'b1;
          end
        end
        if (d) begin
          ep[c]   = N'(1) << k;
          ea[c+1] = N'(1) << k;
          ex[c] = {px, phf}; ex[c+1] = {px, phf};
          ey[c] = {py, pvf}; ey[c+1] = {py, pvf};
          ev[c] = pv;        ev[c+1] = pv;
          c += 3;
        end else begin
          c += 1;
        end
      end
      for (int j = 0; j <= c - 2; j++) eb[j] = 1'b1;
      ed[c-1] = 1'b1;
      L = c + 1;
    end

    @(negedge clk);
    bus8.vblank = 1'b1;
    @(posedge clk);
    for (int j = 0; j < L; j++) begin
      @(negedge clk);
      bus8.wr_en = 1'b0;
      chk("busy",     32'(bus8.busy),     32'(eb[j]));
      chk("done",     32'(bus8.done),     32'(ed[j]));
      chk("load_pos", 32'(bus8.load_pos), 32'(ep[j]));
      chk("load_att", 32'(bus8.load_att), 32'(ea[j]));
      if ((ep[j] | ea[j]) != '0) begin
        chk("x",       32'(bus8.x),       32'(ex[j]));
        chk("y",       32'(bus8.y),       32'(ey[j]));
        chk("visible", 32'(bus8.visible), 32'(ev[j]));
      end
      if (j == mw_step) begin
        bus8.wr_en = 1'b1; bus8.wr_addr = 3'(mw_addr); bus8.wr_field = mw_field; bus8.wr_data = mw_data;
      end
      if (j == drop_step) bus8.vblank = 1'b0;
      if (j == rst_step) begin
        rst = 1'b1;
        @(negedge clk);
        chk_zero("rst_mid");
        rst = 1'b0;
        bus8.vblank = 1'b0;
        model_reset();
        return;
      end
    end
    bus8.vblank = 1'b0;
    bus8.wr_en  = 1'b0;
    if (mw_step >= 0) model_fields(mw_addr, mw_field, mw_data);
    mdirty = post;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw, mws, mwa;
    rst = 1'b1;
    bus8.vblank = 1'b1; bus8.wr_en = 1'b0; bus8.wr_addr = '0; bus8.wr_field = 1'b0; bus8.wr_data = '0;
    bus6.vblank = 1'b0; bus6.wr_en = 1'b0; bus6.wr_addr = '0; bus6.wr_field = 1'b0; bus6.wr_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // vblank already high at reset release must not start a commit
    wr(0, 1'b0, 17'h0_1234);
    repeat (5) begin
      @(negedge clk);
      chk("release_busy",     32'(bus8.busy),     32'd0);
      chk("release_load_pos", 32'(bus8.load_pos), 32'd0);
    end
    @(negedge clk);
    bus8.vblank = 1'b0;
    run_frame(-1, 0, 1'b0, '0, -1, -1);

    // Single position write to sprite 2
    wr(2, 1'b0, {9'h0A5, 8'h3C});
    run_frame(-1, 0, 1'b0, '0, -1, -1);
    chk("t1_x_hold", 32'(bus8.x), 32'h14A);
    chk("t1_y_hold", 32'(bus8.y), 32'h078);

    // All sprites dirty, vblank dropped mid-pass
    for (int k = 0; k < N; k++) wr(k, 1'b0, 17'($urandom));
    run_frame(-1, 0, 1'b0, '0, 4, -1);

    // No writes: several frames stay silent
    repeat (3) run_frame(-1, 0, 1'b0, '0, -1, -1);

    // Attribute write to sprite 5 on the very edge its SCAN clears dirty
    wr(5, 1'b0, {9'h155, 8'h22});
    run_frame(5, 5, 1'b1, 17'h00005, -1, -1);
    chk("t4_old_visible", 32'(bus8.visible), 32'd0);
    chk("t4_old_x",       32'(bus8.x),       32'h2AA);
    run_frame(-1, 0, 1'b0, '0, -1, -1);
    chk("t4_new_visible", 32'(bus8.visible), 32'd1);
    chk("t4_new_x",       32'(bus8.x),       32'h2AB);

    // Reset while load_pos[3] is high
    wr(1, 1'b0, 17'h1_5A5A);
    wr(3, 1'b1, 17'h00007);
    run_frame(-1, 0, 1'b0, '0, -1, 6);
    repeat (2) run_frame(-1, 0, 1'b0, '0, -1, -1);

    // Out-of-range write on a 6-sprite instance is ignored
    @(negedge clk);
    bus6.wr_en = 1'b1; bus6.wr_addr = 3'd7; bus6.wr_field = 1'b0; bus6.wr_data = 17'h1_FFFF;
    @(negedge clk);
    bus6.wr_en = 1'b0;
    bus6.vblank = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("t6_busy",     32'(bus6.busy),     32'd0);
      chk("t6_load_pos", 32'(bus6.load_pos), 32'd0);
      chk("t6_load_att", 32'(bus6.load_att), 32'd0);
    end
    bus6.vblank = 1'b0;
    @(negedge clk);
    bus6.wr_en = 1'b1; bus6.wr_addr = 3'd5; bus6.wr_field = 1'b0; bus6.wr_data = 17'h1_FFFF;
    @(negedge clk);
    bus6.wr_en = 1'b0;
    bus6.vblank = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("t6_last_load_pos", 32'(bus6.load_pos), (j == 6) ? 32'h20 : 32'h0);
      chk("t6_last_load_att", 32'(bus6.load_att), (j == 7) ? 32'h20 : 32'h0);
      chk("t6_last_done",     32'(bus6.done),     (j == 8) ? 32'd1 : 32'd0);
      if (j == 6) chk("t6_last_x", 32'(bus6.x), 32'h3FE);
    end
    bus6.vblank = 1'b0;

    // Randomized frames with random writes, mid-pass writes and vblank drops
    repeat (30) begin
      nw = $urandom_range(0, 5);
      for (int i = 0; i < nw; i++) wr($urandom_range(0, N-1), 1'($urandom), 17'($urandom));
      mws = -1;
      mwa = 0;
      if (mdirty != '0 && $urandom_range(0, 1) == 1) begin
        mws = $urandom_range(0, N-1);
        mwa = $urandom_range(0, N-1);
      end
      run_frame(mws, mwa, 1'($urandom), 17'($urandom), $urandom_range(0, 12), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
